// File: rtl/nonce_collector.sv
// Gathers golden nonces from NUM_HASHERS channels through a round-robin arbiter into a FWFT FIFO.
// Optional build macro NONCE_CORRECT_EN subtracts NONCE_OFFSET from each nonce on its way into the FIFO.
module nonce_collector #(
   parameter int          NUM_HASHERS  = 3,
   parameter int          FIFO_DEPTH   = 8,
   parameter int          LED_HOLD     = 2500000,
   parameter logic [31:0] NONCE_OFFSET = 32'd0,
   localparam int         HID_W        = (NUM_HASHERS > 1) ? $clog2(NUM_HASHERS) : 1,
   localparam int         CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                      osc_clk,
   input  logic                      rst,
   input  logic [32*NUM_HASHERS-1:0] nonce_in,
   input  logic [NUM_HASHERS-1:0]    nonce_vld,
   output logic [31:0]               out_nonce,
   output logic [HID_W-1:0]          out_hid,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [CNT_W-1:0]          fifo_count,
   output logic                      overflow,
   output logic                      led_act
);

   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int LED_W = $clog2(LED_HOLD + 1);

   logic [31:0]            slot_nonce [NUM_HASHERS];
   logic [NUM_HASHERS-1:0] pending;
   logic [NUM_HASHERS-1:0] granted;
   logic [HID_W-1:0]       rr_ptr;
   logic [HID_W-1:0]       grant_idx;
   logic [HID_W-1:0]       cand_idx;
   logic                   grant_vld;
   logic                   fifo_room;
   logic                   wr_en;
   logic                   rd_en;
   logic [31:0]            wr_data;

   logic [31:0]            mem_nonce [FIFO_DEPTH];
   logic [HID_W-1:0]       mem_hid   [FIFO_DEPTH];
   logic [AW-1:0]          wr_ptr;
   logic [AW-1:0]          rd_ptr;
   logic [LED_W-1:0]       led_cnt;

   assign out_valid = (fifo_count != '0);
   assign rd_en     = out_valid && out_ready;
   assign fifo_room = (fifo_count != CNT_W'(FIFO_DEPTH)) || rd_en;
   assign wr_en     = grant_vld;
   assign out_nonce = mem_nonce[rd_ptr];
   assign out_hid   = mem_hid[rd_ptr];
   assign led_act   = (led_cnt != '0);

   // Round-robin search begins one past the last granted channel.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand_idx  = '0;
      granted   = '0;
      for (int k = 1; k <= NUM_HASHERS; k++) begin
         cand_idx = HID_W'((int'(rr_ptr) + k) % NUM_HASHERS);
         if (!grant_vld && pending[cand_idx]) begin
            grant_vld = 1'b1;
            grant_idx = cand_idx;
         end
      end
      if (!fifo_room) grant_vld = 1'b0;
      if (grant_vld) granted[grant_idx] = 1'b1;
   end

`ifdef NONCE_CORRECT_EN
   assign wr_data = slot_nonce[grant_idx] - NONCE_OFFSET;
`else
   logic unused_offset;
   assign unused_offset = ^NONCE_OFFSET;
   assign wr_data       = slot_nonce[grant_idx];
`endif

   always_ff @(posedge osc_clk) begin
      for (int i = 0; i < NUM_HASHERS; i++) begin
         if (nonce_vld[i] && (!pending[i] || granted[i])) slot_nonce[i] <= nonce_in[32*i +: 32];
      end
      if (wr_en) begin
         mem_nonce[wr_ptr] <= wr_data;
         mem_hid[wr_ptr]   <= grant_idx;
      end
   end

   // A strobe on a slot that is granted this cycle refills it instead of dropping.
   always_ff @(posedge osc_clk or posedge rst) begin
      if (rst) begin
         pending  <= '0;
         overflow <= 1'b0;
         rr_ptr   <= HID_W'(NUM_HASHERS - 1);
      end else begin
         if (grant_vld) rr_ptr <= grant_idx;
         for (int i = 0; i < NUM_HASHERS; i++) begin
            if (nonce_vld[i]) begin
               if (!pending[i] || granted[i]) pending[i] <= 1'b1;
               else                           overflow   <= 1'b1;
            end else if (granted[i]) begin
               pending[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge osc_clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         led_cnt    <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
         if (wr_en)                led_cnt <= LED_W'(LED_HOLD);
         else if (led_cnt != '0)   led_cnt <= led_cnt - 1'b1;
      end
   end

endmodule

// File: tb/tb_nonce_collector.sv
// Directed bench for nonce_collector: single path, fairness, back-pressure, correction, reset and LED stretch.
module tb_nonce_collector;

   localparam int NH = 3;

   logic          osc_clk = 1'b0;
   logic          rst;
   logic [95:0]   nonce_in;
   logic [2:0]    nonce_vld;
   logic [31:0]   out_nonce;
   logic [1:0]    out_hid;
   logic          out_valid;
   logic          out_ready;
   logic [3:0]    fifo_count;
   logic          overflow;
   logic          led_act;

   int n_cmp = 0;
   int n_err = 0;

   nonce_collector #(
      .NUM_HASHERS (NH),
      .FIFO_DEPTH  (8),
      .LED_HOLD    (10),
      .NONCE_OFFSET(32'd2)
   ) dut (
      .osc_clk   (osc_clk),
      .rst       (rst),
      .nonce_in  (nonce_in),
      .nonce_vld (nonce_vld),
      .out_nonce (out_nonce),
      .out_hid   (out_hid),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .fifo_count(fifo_count),
      .overflow  (overflow),
      .led_act   (led_act)
   );

   always #5 osc_clk = ~osc_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge osc_clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   logic [31:0] exp_corr;

   initial begin
      rst       = 1'b1;
      nonce_in  = '0;
      nonce_vld = '0;
      out_ready = 1'b0;
      idle(2);
      check("rst_valid", 32'(out_valid), 0);
      check("rst_count", 32'(fifo_count), 0);
      check("rst_ovf", 32'(overflow), 0);
      check("rst_led", 32'(led_act), 0);
      rst = 1'b0;
      tick();

      // fairness: two rounds, order 0,1,2 each time
      out_ready = 1'b1;
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < NH; i++) nonce_in[32*i +: 32] = 32'hA000_0000 + 32'(16*r + i);
         nonce_vld = 3'b111;
         tick();
         nonce_vld = '0;
         for (int i = 0; i < NH; i++) begin
            tick();
            check("fair_valid", 32'(out_valid), 1);
            check("fair_hid", 32'(out_hid), 32'(i));
            check("fair_nonce", out_nonce, 32'hA000_0000 + 32'(16*r + i));
         end
         tick();
         check("fair_empty", 32'(out_valid), 0);
      end

      // single nonce on channel 1
      nonce_in[63:32] = 32'hDEADBEEF;
      nonce_vld = 3'b010;
      tick();
      nonce_vld = '0;
      check("single_lat", 32'(out_valid), 0);
      tick();
      check("single_valid", 32'(out_valid), 1);
      check("single_nonce", out_nonce, 32'hDEADBEEF);
      check("single_hid", 32'(out_hid), 1);
      tick();
      check("single_drain", 32'(out_valid), 0);

      // LED: one write holds exactly 10 cycles
      idle(15);
      check("led_idle", 32'(led_act), 0);
      nonce_in[31:0] = 32'h0000_1111;
      nonce_vld = 3'b001;
      tick();
      nonce_vld = '0;
      for (int c = 1; c <= 11; c++) begin
         tick();
         check("led_single", 32'(led_act), (c <= 10) ? 32'd1 : 32'd0);
      end
      // LED: second write at cycle 5 extends to cycle 14
      nonce_vld = 3'b001;
      tick();
      nonce_vld = '0;
      for (int c = 1; c <= 16; c++) begin
         nonce_vld = (c == 4) ? 3'b001 : 3'b000;
         tick();
         nonce_vld = '0;
         check("led_retrig", 32'(led_act), (c <= 14) ? 32'd1 : 32'd0);
      end

      // nonce correction
`ifdef NONCE_CORRECT_EN
      exp_corr = 32'hFFFF_FFFF;
`else
      exp_corr = 32'h0000_0001;
`endif
      nonce_in[31:0] = 32'h0000_0001;
      nonce_vld = 3'b001;
      tick();
      nonce_vld = '0;
      tick();
      check("corr_nonce", out_nonce, exp_corr);
      tick();
      check("corr_drain", 32'(out_valid), 0);

      // back-pressure: nine strobes fill FIFO plus slot, tenth drops
      out_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         nonce_in[31:0] = 32'h1000_0000 + 32'(i);
         nonce_vld = 3'b001;
         tick();
         nonce_vld = '0;
         tick();
      end
      check("bp_count", 32'(fifo_count), 8);
      check("bp_no_ovf", 32'(overflow), 0);
      nonce_in[31:0] = 32'h1000_0009;
      nonce_vld = 3'b001;
      tick();
      nonce_vld = '0;
      tick();
      check("bp_ovf", 32'(overflow), 1);
      check("bp_count_hold", 32'(fifo_count), 8);
      out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         check("bp_valid", 32'(out_valid), 1);
         check("bp_order", out_nonce, 32'h1000_0000 + 32'(i));
         tick();
      end
      check("bp_tenth_absent", 32'(out_valid), 0);
      check("bp_ovf_sticky", 32'(overflow), 1);

      // reset mid-operation: 3 queued, 2 pending
      out_ready = 1'b0;
      for (int i = 0; i < NH; i++) nonce_in[32*i +: 32] = 32'hC000_0000 + 32'(i);
      nonce_vld = 3'b111;
      tick();
      nonce_vld = '0;
      idle(3);
      check("pre_rst_count", 32'(fifo_count), 3);
      nonce_vld = 3'b011;
      tick();
      nonce_vld = '0;
      rst = 1'b1;
      #1;
      check("mid_rst_count", 32'(fifo_count), 0);
      check("mid_rst_valid", 32'(out_valid), 0);
      check("mid_rst_ovf", 32'(overflow), 0);
      check("mid_rst_led", 32'(led_act), 0);
      tick();
      rst = 1'b0;
      tick();
      out_ready = 1'b1;
      nonce_in[95:64] = 32'h2222_2222;
      nonce_vld = 3'b100;
      tick();
      nonce_vld = '0;
      tick();
      check("post_rst_valid", 32'(out_valid), 1);
      check("post_rst_hid", 32'(out_hid), 2);
      check("post_rst_nonce", out_nonce, 32'h2222_2222);
      tick();
      check("post_rst_discard", 32'(out_valid), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
